// File: rtl/ext_pkg.sv
// ext_pkg -- shared definitions for the extending ALU result pipe.
//   ext_width_e             : encoding of the widthSel field-width selector
//   EXT_UPPER_SHIFT_DEFAULT : default upper-immediate shift used by auiPc mode
package ext_pkg;

  typedef enum logic [1:0] {
    EXT_FULL = 2'b00,  // no extension, value passes through
    EXT_WORD = 2'b01,  // 32-bit field
    EXT_HALF = 2'b10,  // 16-bit field
    EXT_BYTE = 2'b11   // 8-bit field
  } ext_width_e;

  localparam int EXT_UPPER_SHIFT_DEFAULT = 12;

endpackage : ext_pkg

// File: rtl/ext_unit.sv
// ext_unit -- combinational sign/zero extension of the low field of a value.
// Ports:
//   data_i      in  XLEN  raw value
//   width_sel_i in  2     field width select (ext_width_e encoding)
//   sign_ext_i  in  1     1 = fill with field MSB, 0 = fill with zeros
//   ext_o       out XLEN  extended value
module ext_unit
  import ext_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      width_sel_i,
  input  logic            sign_ext_i,
  output logic [XLEN-1:0] ext_o
);

  localparam int IDX_W = $clog2(XLEN);

  int               fw;
  logic [IDX_W-1:0] msb_idx;
  logic             fill;

  always_comb begin
    fw = XLEN;
    case (width_sel_i)
      EXT_WORD: fw = 32;
      EXT_HALF: fw = 16;
      EXT_BYTE: fw = 8;
      default:  fw = XLEN;
    endcase
    msb_idx = IDX_W'(fw - 1);
    fill    = sign_ext_i & data_i[msb_idx];
    // Bits inside the field are kept; bits above it take the fill value.
    // A 32-bit field on a 32-bit datapath therefore degenerates to full mode.
    ext_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      ext_o[i] = (i < fw) ? data_i[i] : fill;
    end
  end

endmodule : ext_unit

// File: rtl/ext_alu_pipe.sv
// ext_alu_pipe -- extends two operands and an ALU result to the selected
// field width, then buffers them with their tag in a DEPTH-entry FIFO.
// Ports:
//   clk, rstN                         clock, asynchronous active-low reset
//   flush                             synchronous discard of all entries
//   inValid/inReady                   input handshake
//   dataRs1, dataRs2, resultAlu       raw values (XLEN)
//   widthSel, signExt, auiPc, inTag   extension controls and tag
//   outValid/outReady                 output handshake
//   outRs1, outRs2, outResultAlu      head-entry extended values (XLEN)
//   outTag                            head-entry tag
//   count                             number of buffered entries
module ext_alu_pipe
  import ext_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH       = 2,
  parameter int UPPER_SHIFT = EXT_UPPER_SHIFT_DEFAULT,
  parameter int TAG_W       = 5
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       flush,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [XLEN-1:0]            dataRs1,
  input  logic [XLEN-1:0]            dataRs2,
  input  logic [XLEN-1:0]            resultAlu,
  input  logic [1:0]                 widthSel,
  input  logic                       signExt,
  input  logic                       auiPc,
  input  logic [TAG_W-1:0]           inTag,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [XLEN-1:0]            outRs1,
  output logic [XLEN-1:0]            outRs2,
  output logic [XLEN-1:0]            outResultAlu,
  output logic [TAG_W-1:0]           outTag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------- extension
  logic [XLEN-1:0] raw_v [3];
  logic [XLEN-1:0] ext_v [3];
  logic [XLEN-1:0] res_wr;

  assign raw_v[0] = dataRs1;
  assign raw_v[1] = dataRs2;
  assign raw_v[2] = resultAlu;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ext
    ext_unit #(
      .XLEN(XLEN)
    ) u_ext (
      .data_i     (raw_v[gi]),
      .width_sel_i(widthSel),
      .sign_ext_i (signExt),
      .ext_o      (ext_v[gi])
    );
  end

  // auiPc overrides the result extension only; operands still get extended.
  assign res_wr = auiPc ? (resultAlu << UPPER_SHIFT) : ext_v[2];

  // ------------------------------------------------------------ FIFO control
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign inReady  = (count_q != CNT_W'(DEPTH));
  assign outValid = (count_q != '0);
  assign push     = inValid & inReady;
  assign pop      = outValid & outReady;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------- storage
  // Data entries carry no reset; they are only observed while outValid=1.
  logic [XLEN-1:0]  mem_rs1_q [DEPTH];
  logic [XLEN-1:0]  mem_rs2_q [DEPTH];
  logic [XLEN-1:0]  mem_res_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_rs1_q[wr_ptr_q] <= ext_v[0];
      mem_rs2_q[wr_ptr_q] <= ext_v[1];
      mem_res_q[wr_ptr_q] <= res_wr;
      mem_tag_q[wr_ptr_q] <= inTag;
    end
  end

  assign outRs1       = mem_rs1_q[rd_ptr_q];
  assign outRs2       = mem_rs2_q[rd_ptr_q];
  assign outResultAlu = mem_res_q[rd_ptr_q];
  assign outTag       = mem_tag_q[rd_ptr_q];

endmodule : ext_alu_pipe

// File: tb/tb_ext_alu_pipe.sv
// tb_ext_alu_pipe -- randomized and directed bench for ext_alu_pipe
// (XLEN=64, DEPTH=2) against a queue-based reference model.
module tb_ext_alu_pipe;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstN;
  logic             flush;
  logic             inValid;
  logic             inReady;
  logic [XLEN-1:0]  dataRs1, dataRs2, resultAlu;
  logic [1:0]       widthSel;
  logic             signExt;
  logic             auiPc;
  logic [TAG_W-1:0] inTag;
  logic             outValid;
  logic             outReady;
  logic [XLEN-1:0]  outRs1, outRs2, outResultAlu;
  logic [TAG_W-1:0] outTag;
  logic [1:0]       count;

  always #5 clk = ~clk;

  ext_alu_pipe #(
    .XLEN(XLEN), .DEPTH(DEPTH), .UPPER_SHIFT(12), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .dataRs1(dataRs1), .dataRs2(dataRs2), .resultAlu(resultAlu),
    .widthSel(widthSel), .signExt(signExt), .auiPc(auiPc), .inTag(inTag),
    .outValid(outValid), .outReady(outReady),
    .outRs1(outRs1), .outRs2(outRs2), .outResultAlu(outResultAlu),
    .outTag(outTag), .count(count)
  );

  typedef struct {
    logic [63:0]      rs1;
    logic [63:0]      rs2;
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t model_q [$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Field extension from arithmetic on masks.
  function automatic logic [63:0] ext_model(input logic [63:0] v, input logic [1:0] ws,
                                            input logic se);
    int          w;
    logic [63:0] mask;
    logic        sign;
    case (ws)
      2'b01:   w = 32;
      2'b10:   w = 16;
      2'b11:   w = 8;
      default: w = 64;
    endcase
    if (w == 64) return v;
    mask = (64'd1 << w) - 64'd1;
    sign = ((v >> (w - 1)) & 64'd1) != 0;
    return (v & mask) | ((se && sign) ? ~mask : 64'd0);
  endfunction

  task automatic check_state(input string pfx);
    check({pfx, "_count"}, 64'(count), 64'(model_q.size()));
    check({pfx, "_outvalid"}, 64'(outValid), 64'(model_q.size() != 0));
    check({pfx, "_inready"}, 64'(inReady), 64'(model_q.size() != DEPTH));
    if (model_q.size() != 0) begin
      check({pfx, "_rs1"}, outRs1, model_q[0].rs1);
      check({pfx, "_rs2"}, outRs2, model_q[0].rs2);
      check({pfx, "_res"}, outResultAlu, model_q[0].res);
      check({pfx, "_tag"}, 64'(outTag), 64'(model_q[0].tag));
    end
  endtask

  // Called at a negedge: drive inputs, advance one clock, update model, check.
  task automatic cycle(input string pfx, input logic iv, input logic ordy, input logic fl,
                       input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] r,
                       input logic [1:0] ws, input logic se, input logic aui,
                       input logic [TAG_W-1:0] tag);
    exp_t e;
    bit   do_push, do_pop;
    inValid = iv; outReady = ordy; flush = fl;
    dataRs1 = d1; dataRs2 = d2; resultAlu = r;
    widthSel = ws; signExt = se; auiPc = aui; inTag = tag;
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() != 0);
    e.rs1 = ext_model(d1, ws, se);
    e.rs2 = ext_model(d2, ws, se);
    e.res = aui ? (r << 12) : ext_model(r, ws, se);
    e.tag = tag;
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    @(negedge clk);
    check_state(pfx);
  endtask

  task automatic idle(input string pfx, input logic ordy);
    cycle(pfx, 1'b0, ordy, 1'b0, 64'd0, 64'd0, 64'd0, 2'b00, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rstN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    dataRs1 = '0; dataRs2 = '0; resultAlu = '0;
    widthSel = 2'b00; signExt = 1'b0; auiPc = 1'b0; inTag = '0;
    repeat (2) @(negedge clk);
    check_state("reset");
    rstN = 1'b1;
    @(negedge clk);
    check_state("post_reset");

    // Word sign/zero extension of operand 1.
    cycle("w_sx", 1, 0, 0, 64'h0000_0000_8000_0001, 64'h1234_5678_0000_7fff, 64'h0,
          2'b01, 1'b1, 1'b0, 5'd1);
    check("w_sx_const", outRs1, 64'hFFFF_FFFF_8000_0001);
    cycle("w_zx", 1, 1, 0, 64'h0000_0000_8000_0001, 64'hFFFF_0000_FFFF_FFFF, 64'h0,
          2'b01, 1'b0, 1'b0, 5'd2);
    check("w_zx_const", outRs1, 64'h0000_0000_8000_0001);
    idle("drain_a", 1);

    // Byte sign extension of the result, then auiPc shift.
    cycle("b_sx", 1, 0, 0, 64'h0, 64'h0, 64'h0000_0000_0000_0080, 2'b11, 1'b1, 1'b0, 5'd3);
    check("b_sx_const", outResultAlu, 64'hFFFF_FFFF_FFFF_FF80);
    cycle("aui", 1, 1, 0, 64'h0, 64'h0, 64'h0000_0000_0001_2345, 2'b11, 1'b1, 1'b1, 5'd4);
    check("aui_const", outResultAlu, 64'h0000_0000_1234_5000);
    idle("drain_b", 1);

    // Backpressure: three offers with outReady=0 give two accepts.
    for (int i = 0; i < 3; i++)
      cycle("bp_fill", 1, 0, 0, 64'(i), 64'(i), 64'(i), 2'b00, 1'b0, 1'b0, 5'(10 + i));
    check("bp_inready", 64'(inReady), 64'd0);
    check("bp_count", 64'(count), 64'd2);
    check("bp_head", 64'(outTag), 64'd10);
    idle("bp_drain0", 1);
    check("bp_second", 64'(outTag), 64'd11);
    idle("bp_drain1", 1);

    // Full-rate streaming: count settles at 1, tags follow in order.
    for (int i = 0; i < 10; i++) begin
      cycle("stream", 1, 1, 0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            2'($urandom_range(0, 3)), 1'($urandom), 1'b0, 5'(i));
      check("stream_tag", 64'(outTag), 64'(i));
    end
    idle("stream_end", 1);

    // Flush with a simultaneous push drops everything.
    cycle("fl_fill0", 1, 0, 0, 64'h1, 64'h1, 64'h1, 2'b00, 1'b0, 1'b0, 5'd20);
    cycle("fl_fill1", 1, 0, 0, 64'h2, 64'h2, 64'h2, 2'b00, 1'b0, 1'b0, 5'd21);
    cycle("flush", 1, 1, 1, 64'h3, 64'h3, 64'h3, 2'b00, 1'b0, 1'b0, 5'd22);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(outValid), 64'd0);
    idle("flush_after", 1);

    // Asynchronous reset between edges while one entry is held.
    cycle("ar_fill", 1, 0, 0, 64'h5, 64'h5, 64'h5, 2'b00, 1'b0, 1'b0, 5'd30);
    inValid = 1'b0;
    #2 rstN = 1'b0;
    #1;
    check("ar_valid", 64'(outValid), 64'd0);
    check("ar_count", 64'(count), 64'd0);
    check("ar_ready", 64'(inReady), 64'd1);
    model_q.delete();
    @(negedge clk);
    rstN = 1'b1;
    cycle("ar_push7", 1, 0, 0, 64'h7, 64'h7, 64'h7, 2'b00, 1'b0, 1'b0, 5'd7);
    check("ar_tag7", 64'(outTag), 64'd7);
    idle("ar_drain", 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ext_alu_pipe
